// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// The master side is the ALU/writeback environment; the slave side is the stage.
`ifndef N_FLAG
`define N_FLAG 3
`endif
`ifndef Z_FLAG
`define Z_FLAG 2
`endif
`ifndef C_FLAG
`define C_FLAG 1
`endif
`ifndef V_FLAG
`define V_FLAG 0
`endif

interface alu_result_stage_if #(
    parameter int DATA_W     = 16,
    parameter int FR_FLAG_W  = 4,
    parameter int REG_ADDR_W = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_y;
    logic [FR_FLAG_W-1:0]  in_flags;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_rd_we;
    logic                  in_flag_we;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_y;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_rd_we;

    modport master (
        output in_valid, in_y, in_flags, in_rd, in_rd_we, in_flag_we, out_ready,
        input  in_ready, out_valid, out_y, out_rd, out_rd_we
    );

    modport slave (
        input  in_valid, in_y, in_flags, in_rd, in_rd_we, in_flag_we, out_ready,
        output in_ready, out_valid, out_y, out_rd, out_rd_we
    );
endinterface

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: 2-entry in-order skid FIFO toward writeback,
// plus the architectural flag register and branch-condition evaluation.
`ifndef N_FLAG
`define N_FLAG 3
`endif
`ifndef Z_FLAG
`define Z_FLAG 2
`endif
`ifndef C_FLAG
`define C_FLAG 1
`endif
`ifndef V_FLAG
`define V_FLAG 0
`endif

module alu_result_stage #(
    parameter int DATA_W     = 16,
    parameter int FR_FLAG_W  = 4,
    parameter int REG_ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_stage_if.slave    bus,
    output logic [FR_FLAG_W-1:0] fr,
    input  logic                 fr_we_ext,
    input  logic [FR_FLAG_W-1:0] fr_wdata,
    input  logic                 flush,
    input  logic [3:0]           cond,
    output logic                 cond_true
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                state, state_next;
    logic                  push, pop;
    logic                  head_load, head_from_tail, tail_load, clear_head_we;
    logic                  in_ready_q, out_valid_q;
    logic [DATA_W-1:0]     head_y, tail_y;
    logic [REG_ADDR_W-1:0] head_rd, tail_rd;
    logic                  head_rd_we, tail_rd_we;

    assign push = bus.in_valid & in_ready_q & ~flush;
    assign pop  = out_valid_q & bus.out_ready & ~flush;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = head_y;
    assign bus.out_rd    = head_rd;
    assign bus.out_rd_we = head_rd_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next != FULL);
            out_valid_q <= (state_next != EMPTY);
        end
    end

    // A simultaneous push and pop at ONE replaces the head with the incoming entry.
    always_comb begin
        state_next     = state;
        head_load      = 1'b0;
        head_from_tail = 1'b0;
        tail_load      = 1'b0;
        clear_head_we  = 1'b0;
        if (flush) begin
            state_next    = EMPTY;
            clear_head_we = 1'b1;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    state_next = ONE;
                    head_load  = 1'b1;
                end
                ONE: if (push && pop) begin
                    head_load = 1'b1;
                end else if (pop) begin
                    state_next    = EMPTY;
                    clear_head_we = 1'b1;
                end else if (push) begin
                    state_next = FULL;
                    tail_load  = 1'b1;
                end
                FULL: if (pop) begin
                    state_next     = ONE;
                    head_from_tail = 1'b1;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_y     <= '0;
            head_rd    <= '0;
            head_rd_we <= 1'b0;
            tail_y     <= '0;
            tail_rd    <= '0;
            tail_rd_we <= 1'b0;
        end else begin
            if (head_load) begin
                head_y     <= bus.in_y;
                head_rd    <= bus.in_rd;
                head_rd_we <= bus.in_rd_we;
            end else if (head_from_tail) begin
                head_y     <= tail_y;
                head_rd    <= tail_rd;
                head_rd_we <= tail_rd_we;
            end else if (clear_head_we) begin
                head_rd_we <= 1'b0;
            end
            if (tail_load) begin
                tail_y     <= bus.in_y;
                tail_rd    <= bus.in_rd;
                tail_rd_we <= bus.in_rd_we;
            end
        end
    end

    // Flags update at accept so the very next instruction branches on them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr <= '0;
        end else if (fr_we_ext) begin
            fr <= fr_wdata;
        end else if (push && bus.in_flag_we) begin
            fr <= bus.in_flags;
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'h0: cond_true = 1'b1;
            4'h1: cond_true = fr[`Z_FLAG];
            4'h2: cond_true = ~fr[`Z_FLAG];
            4'h3: cond_true = fr[`C_FLAG];
            4'h4: cond_true = ~fr[`C_FLAG];
            4'h5: cond_true = fr[`N_FLAG];
            4'h6: cond_true = ~fr[`N_FLAG];
            4'h7: cond_true = fr[`V_FLAG];
            4'h8: cond_true = ~fr[`V_FLAG];
            4'h9: cond_true = fr[`C_FLAG];
            4'hA: cond_true = ~fr[`C_FLAG];
            4'hB: cond_true = ~fr[`Z_FLAG] & (fr[`N_FLAG] == fr[`V_FLAG]);
            4'hC: cond_true = (fr[`N_FLAG] == fr[`V_FLAG]);
            4'hD: cond_true = (fr[`N_FLAG] != fr[`V_FLAG]);
            4'hE: cond_true = fr[`Z_FLAG] | (fr[`N_FLAG] != fr[`V_FLAG]);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed steps followed by random traffic,
// all compared against a queue-based reference model of the stage.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] fr;
    logic       fr_we_ext = 1'b0;
    logic [3:0] fr_wdata = '0;
    logic       flush = 1'b0;
    logic [3:0] cond = '0;
    logic       cond_true;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] y;
        logic [2:0]  rd;
        logic        we;
    } entry_t;

    entry_t     model_q[$];
    logic [3:0] model_fr = '0;

    alu_result_stage_if #(.DATA_W(16), .FR_FLAG_W(4), .REG_ADDR_W(3)) bus ();

    alu_result_stage #(.DATA_W(16), .FR_FLAG_W(4), .REG_ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .fr        (fr),
        .fr_we_ext (fr_we_ext),
        .fr_wdata  (fr_wdata),
        .flush     (flush),
        .cond      (cond),
        .cond_true (cond_true)
    );

    always #5 clk = ~clk;

    // Flag layout: bit3=N, bit2=Z, bit1=C, bit0=V.
    function automatic logic condModel(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, signed_lt;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        signed_lt = n ^ v;
        case (c)
            4'h0: return 1'b1;
            4'h1: return z;
            4'h2: return !z;
            4'h3, 4'h9: return cy;
            4'h4, 4'hA: return !cy;
            4'h5: return n;
            4'h6: return !n;
            4'h7: return v;
            4'h8: return !v;
            4'hB: return !z && !signed_lt;
            4'hC: return !signed_lt;
            4'hD: return signed_lt;
            4'hE: return z || signed_lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] y, input logic [3:0] flags,
                                 input logic [2:0] rd, input logic rd_we, input logic flag_we);
        bus.in_valid   = v;
        bus.in_y       = y;
        bus.in_flags   = flags;
        bus.in_rd      = rd;
        bus.in_rd_we   = rd_we;
        bus.in_flag_we = flag_we;
    endtask

    task automatic checkModel(input string tag);
        logic vld;
        vld = (model_q.size() > 0);
        checkOutput({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, vld});
        checkOutput({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, model_q.size() < 2});
        checkOutput({tag, ".out_rd_we"}, {31'd0, bus.out_rd_we}, {31'd0, vld ? model_q[0].we : 1'b0});
        if (vld) begin
            checkOutput({tag, ".out_y"}, {16'd0, bus.out_y}, {16'd0, model_q[0].y});
            checkOutput({tag, ".out_rd"}, {29'd0, bus.out_rd}, {29'd0, model_q[0].rd});
        end
        checkOutput({tag, ".fr"}, {28'd0, fr}, {28'd0, model_fr});
        checkOutput({tag, ".cond_true"}, {31'd0, cond_true}, {31'd0, condModel(cond, model_fr)});
    endtask

    // One clock edge: predict from the model's view, advance, then compare.
    task automatic cycle(input string tag);
        logic   acc, pop;
        entry_t e;
        acc = bus.in_valid && (model_q.size() < 2) && !flush;
        pop = (model_q.size() > 0) && bus.out_ready && !flush;
        e.y = bus.in_y; e.rd = bus.in_rd; e.we = bus.in_rd_we;
        @(posedge clk);
        #1;
        if (flush) model_q.delete();
        else begin
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(e);
        end
        if (fr_we_ext) model_fr = fr_wdata;
        else if (acc && bus.in_flag_we) model_fr = bus.in_flags;
        checkModel(tag);
    endtask

    initial begin
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkModel("reset");
        checkOutput("reset.in_ready_hi", {31'd0, bus.in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single push with writeback ready: one cycle visible, then gone.
        applyStimulus(1'b1, 16'h1234, '0, 3'd3, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        cycle("push1");
        checkOutput("push1.y_const", {16'd0, bus.out_y}, 32'h1234);
        checkOutput("push1.rd_const", {29'd0, bus.out_rd}, 32'd3);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle("drain1");
        checkOutput("drain1.valid_const", {31'd0, bus.out_valid}, 32'd0);

        // Fill with writeback stalled, third push refused, then in-order drain.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0001, '0, 3'd1, 1'b1, 1'b0);
        cycle("fill1");
        applyStimulus(1'b1, 16'h0002, '0, 3'd2, 1'b0, 1'b0);
        cycle("fill2");
        checkOutput("fill2.in_ready_lo", {31'd0, bus.in_ready}, 32'd0);
        applyStimulus(1'b1, 16'h0003, '0, 3'd3, 1'b1, 1'b0);
        cycle("fill3");
        checkOutput("fill3.head_const", {16'd0, bus.out_y}, 32'h0001);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        cycle("pop1");
        checkOutput("pop1.head_const", {16'd0, bus.out_y}, 32'h0002);
        cycle("pop2");
        checkOutput("pop2.valid_const", {31'd0, bus.out_valid}, 32'd0);

        // Flags load on accept only when in_flag_we is set.
        cond = 4'h1;
        applyStimulus(1'b1, 16'h00AA, 4'b0100, 3'd4, 1'b1, 1'b1);
        cycle("flag_we1");
        checkOutput("flag_we1.fr_const", {28'd0, fr}, 32'h4);
        checkOutput("flag_we1.eq_const", {31'd0, cond_true}, 32'd1);
        applyStimulus(1'b1, 16'h00BB, 4'b1001, 3'd5, 1'b1, 1'b0);
        cycle("flag_we0");
        checkOutput("flag_we0.fr_const", {28'd0, fr}, 32'h4);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);

        // Signed comparisons from direct FR writes.
        fr_we_ext = 1'b1; fr_wdata = 4'b1000;
        cycle("ext_n");
        fr_we_ext = 1'b0;
        cond = 4'hD; #1;
        checkOutput("lt_nv10", {31'd0, cond_true}, 32'd1);
        cond = 4'hC; #1;
        checkOutput("ge_nv10", {31'd0, cond_true}, 32'd0);
        fr_we_ext = 1'b1; fr_wdata = 4'b1001; cond = 4'hB;
        cycle("ext_nv");
        checkOutput("gt_z0", {31'd0, cond_true}, 32'd1);
        fr_wdata = 4'b1101;
        cycle("ext_nzv");
        checkOutput("gt_z1", {31'd0, cond_true}, 32'd0);

        // Direct write beats an accepted flag update in the same cycle.
        fr_wdata = 4'b0011;
        applyStimulus(1'b1, 16'h0C0C, 4'b1100, 3'd6, 1'b1, 1'b1);
        cycle("ext_prio");
        checkOutput("ext_prio.fr_const", {28'd0, fr}, 32'h3);
        fr_we_ext = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle("idle");

        // Flush with a full FIFO drops the incoming entry and its flags.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'h1111, '0, 3'd1, 1'b1, 1'b0);
        cycle("pre_flush1");
        applyStimulus(1'b1, 16'h2222, '0, 3'd2, 1'b1, 1'b0);
        cycle("pre_flush2");
        applyStimulus(1'b1, 16'h3333, 4'b1111, 3'd3, 1'b1, 1'b1);
        flush = 1'b1;
        cycle("flush");
        checkOutput("flush.valid_const", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("flush.fr_const", {28'd0, fr}, 32'h3);
        flush = 1'b0;

        // Asynchronous reset mid-stream, checked before any clock edge.
        applyStimulus(1'b1, 16'h4444, 4'b0110, 3'd7, 1'b1, 1'b1);
        cycle("pre_rst1");
        cycle("pre_rst2");
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        model_fr = '0;
        checkModel("async_rst");
        checkOutput("async_rst.out_y", {16'd0, bus.out_y}, 32'd0);
        checkOutput("async_rst.out_rd", {29'd0, bus.out_rd}, 32'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom),
                          3'($urandom), 1'($urandom), 1'($urandom));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            fr_we_ext     = ($urandom_range(0, 9) == 0);
            fr_wdata      = 4'($urandom);
            cond          = 4'($urandom);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
